// File: rtl/relu_wb.sv
// relu_wb: writeback stage for the two-lane MAC datapath.
// Captures a pair of signed accumulator results, applies ReLU, rescales by a
// rounding right shift, saturates to the activation width and writes the two
// words to activation memory on consecutive cycles at sequential addresses.
// After N_OUT neurons have been written the block parks in DONE until reset.
module relu_wb #(
  parameter int                    ACC_WIDTH   = 32,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    FRAC_SHIFT  = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_O = 16'h0000,
  parameter int                    N_OUT       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reset,
  input  logic                         acc_valid,
  input  logic signed [ACC_WIDTH-1:0]  acc0,
  input  logic signed [ACC_WIDTH-1:0]  acc1,
  output logic                         acc_ready,
  output logic                         mem_we,
  output logic        [ADDR_WIDTH-1:0] mem_addr,
  output logic        [DATA_WIDTH-1:0] mem_wdata,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_WR0  = 3'd2,
    S_WR1  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Largest positive activation, e.g. 16'h7FFF for a 16-bit word.
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  // Rounding constant and saturation bound, both in the widened ACC_WIDTH+1 domain.
  localparam logic [ACC_WIDTH:0]    ROUND_C  = (ACC_WIDTH+1)'(1) << (FRAC_SHIFT-1);
  localparam logic [ACC_WIDTH:0]    SAT_C    = (ACC_WIDTH+1)'(DATA_MAX);
  // Counter value at which the write in flight is the layer's final neuron.
  localparam logic [31:0]           LAST_C   = 32'(N_OUT - 1);

  // ReLU, round-half-up rescale and saturate. The extra top bit keeps the
  // rounding add from wrapping for accumulators near the positive limit.
  function automatic logic [DATA_WIDTH-1:0] relu_scale(input logic signed [ACC_WIDTH-1:0] x);
    logic [ACC_WIDTH:0]    sum;
    logic [ACC_WIDTH:0]    shifted;
    logic [DATA_WIDTH-1:0] res;
    sum     = {1'b0, x} + ROUND_C;
    shifted = sum >> FRAC_SHIFT;
    if (x[ACC_WIDTH-1]) begin
      res = {DATA_WIDTH{1'b0}};
    end else if (shifted > SAT_C) begin
      res = DATA_MAX;
    end else begin
      res = shifted[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  state_t                r_state;
  logic [31:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_h0;
  logic [DATA_WIDTH-1:0] r_h1;

  logic [DATA_WIDTH-1:0] w_f0;
  logic [DATA_WIDTH-1:0] w_f1;
  logic                  w_last;
  logic [31:0]           w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_addr_cur;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_f0       = relu_scale(acc0);
  assign w_f1       = relu_scale(acc1);
  assign w_last     = (r_cnt == LAST_C);
  assign w_cnt_inc  = r_cnt + 32'd1;
  // Addresses wrap naturally modulo 2^ADDR_WIDTH.
  assign w_addr_cur = ADDR_BASE_O + ADDR_WIDTH'(r_cnt);
  assign w_addr_nxt = ADDR_BASE_O + ADDR_WIDTH'(w_cnt_inc);

  // Sequencer: state, neuron counter, holding registers and Moore outputs,
  // with the outputs registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 32'd0;
      r_h0      <= {DATA_WIDTH{1'b0}};
      r_h1      <= {DATA_WIDTH{1'b0}};
      acc_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata <= {DATA_WIDTH{1'b0}};
      done      <= 1'b0;
    end else if (reset) begin
      // Soft clear wins over start and aborts any write in progress.
      r_state   <= S_IDLE;
      r_cnt     <= 32'd0;
      r_h0      <= {DATA_WIDTH{1'b0}};
      r_h1      <= {DATA_WIDTH{1'b0}};
      acc_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata <= {DATA_WIDTH{1'b0}};
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_WAIT;
            r_cnt     <= 32'd0;
            acc_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          // acc_ready is high throughout WAIT, so acc_valid alone is the handshake.
          if (acc_valid) begin
            r_h0      <= w_f0;
            r_h1      <= w_f1;
            r_state   <= S_WR0;
            acc_ready <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= w_addr_cur;
            mem_wdata <= w_f0;
          end
        end
        S_WR0: begin
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            // Odd layer size: lane 1 of the final pair is dropped.
            r_state <= S_DONE;
            mem_we  <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state   <= S_WR1;
            mem_we    <= 1'b1;
            mem_addr  <= w_addr_nxt;
            mem_wdata <= r_h1;
          end
        end
        S_WR1: begin
          r_cnt  <= w_cnt_inc;
          mem_we <= 1'b0;
          if (w_last) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_state   <= S_WAIT;
            acc_ready <= 1'b1;
          end
        end
        S_DONE: begin
          acc_ready <= 1'b0;
          mem_we    <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= 32'd0;
          acc_ready <= 1'b0;
          mem_we    <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_wb.sv
// tb_relu_wb: directed scoreboard bench for relu_wb. Three instances with
// layer sizes 4, 6 and 3 share the data inputs; each has its own start.
module tb_relu_wb;

  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int FS  = 8;
  localparam int ADW = 16;

  typedef struct {
    int             cyc;
    logic [ADW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic reset;
  logic acc_valid;
  logic signed [AW-1:0] acc0;
  logic signed [AW-1:0] acc1;
  logic start4, start6, start3;
  logic rdy4, rdy6, rdy3;
  logic we4, we6, we3;
  logic done4, done6, done3;
  logic [ADW-1:0] addr4, addr6, addr3;
  logic [DW-1:0]  wd4, wd6, wd3;

  int  n_asserts   = 0;
  int  n_fail      = 0;
  int  cyc         = 0;
  int  sel         = 0;
  int  mcnt        = 0;
  int  n_out       = 4;
  int  last_wr_cyc = 0;
  bit  mon_en      = 1'b0;
  wr_t sb[$];
  wr_t mon_e;

  logic           m_rdy, m_we, m_done;
  logic [ADW-1:0] m_addr;
  logic [DW-1:0]  m_wd;
  logic [2:0]     stray;

  relu_wb #(.N_OUT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .reset(reset), .acc_valid(acc_valid),
    .acc0(acc0), .acc1(acc1), .acc_ready(rdy4), .mem_we(we4), .mem_addr(addr4),
    .mem_wdata(wd4), .done(done4));

  relu_wb #(.N_OUT(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .reset(reset), .acc_valid(acc_valid),
    .acc0(acc0), .acc1(acc1), .acc_ready(rdy6), .mem_we(we6), .mem_addr(addr6),
    .mem_wdata(wd6), .done(done6));

  relu_wb #(.N_OUT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .reset(reset), .acc_valid(acc_valid),
    .acc0(acc0), .acc1(acc1), .acc_ready(rdy3), .mem_we(we3), .mem_addr(addr3),
    .mem_wdata(wd3), .done(done3));

  always #5 clk = ~clk;

  // Cycle index: the value seen after a rising edge names that cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Route the instance under test to the monitor.
  always_comb begin
    m_rdy = rdy4; m_we = we4; m_done = done4; m_addr = addr4; m_wd = wd4;
    case (sel)
      1: begin m_rdy = rdy6; m_we = we6; m_done = done6; m_addr = addr6; m_wd = wd6; end
      2: begin m_rdy = rdy3; m_we = we3; m_done = done3; m_addr = addr3; m_wd = wd3; end
      default: begin end
    endcase
    stray = {we3, we6, we4} & ~(3'b001 << sel);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference transform in plain integer arithmetic.
  function automatic logic [DW-1:0] model_f(input logic signed [AW-1:0] x);
    longint v;
    longint r;
    v = longint'(x);
    if (v < 0) r = 0;
    else r = (v + (longint'(1) << (FS-1))) / (longint'(1) << FS);
    if (r > ((longint'(1) << (DW-1)) - 1)) r = (longint'(1) << (DW-1)) - 1;
    return DW'(r);
  endfunction

  // Write monitor: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      check("stray_write", {61'd0, stray}, 64'd0);
      if (m_we) begin
        check("write_expected", {63'd0, (sb.size() > 0)}, 64'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("write_addr", {48'd0, m_addr}, {48'd0, mon_e.addr});
          check("write_data", {48'd0, m_wd}, {48'd0, mon_e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int idx, input int nout);
    sel   = idx;
    n_out = nout;
    mcnt  = 0;
    start4 = (idx == 0);
    start6 = (idx == 1);
    start3 = (idx == 2);
    tick();
    start4 = 1'b0; start6 = 1'b0; start3 = 1'b0;
  endtask

  task automatic soft_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("srst_ready", {63'd0, m_rdy}, 64'd0);
    check("srst_done", {63'd0, m_done}, 64'd0);
    check("srst_we", {63'd0, m_we}, 64'd0);
    tick();
  endtask

  // Offer a pair; keep = how many lane writes are expected to survive.
  task automatic send_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input bit hold, input int keep, output int cap);
    bit  got;
    wr_t e;
    got = 1'b0;
    cap = -1;
    acc0 = a0; acc1 = a1; acc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_rdy) begin got = 1'b1; break; end
    end
    check("pair_accepted", {63'd0, got}, 64'd1);
    if (got) begin
      cap = cyc + 1;
      if (mcnt < n_out) begin
        e.cyc = cap; e.addr = ADW'(mcnt); e.data = model_f(a0);
        if (keep >= 1) sb.push_back(e);
        last_wr_cyc = cap;
        mcnt++;
        if (mcnt < n_out) begin
          e.cyc = cap + 1; e.addr = ADW'(mcnt); e.data = model_f(a1);
          if (keep >= 2) sb.push_back(e);
          last_wr_cyc = cap + 1;
          mcnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!hold) acc_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cyc >= last_wr_cyc) break;
    end
    check("last_write_we", {63'd0, m_we}, 64'd1);
    check("done_before_end", {63'd0, m_done}, 64'd0);
    @(negedge clk);
    check("done_rise", {63'd0, m_done}, 64'd1);
    check("done_we_low", {63'd0, m_we}, 64'd0);
    check("done_ready_low", {63'd0, m_rdy}, 64'd0);
    repeat (3) @(negedge clk);
    check("done_held", {63'd0, m_done}, 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c1, c2, c3;
    rst = 1'b0; reset = 1'b0; acc_valid = 1'b0;
    acc0 = '0; acc1 = '0;
    start4 = 1'b0; start6 = 1'b0; start3 = 1'b0;

    // Reset state
    #1;
    check("rst_ready", {63'd0, rdy4}, 64'd0);
    check("rst_we", {63'd0, we4}, 64'd0);
    check("rst_addr", {48'd0, addr4}, 64'd0);
    check("rst_wdata", {48'd0, wd4}, 64'd0);
    check("rst_done", {63'd0, done4}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // 1: basic layer, N_OUT=4
    start_layer(0, 4);
    send_pair(32'h0000_0300, 32'hFFFF_FF00, 1'b0, 2, c1);
    send_pair(32'h0000_0180, 32'h0000_00FF, 1'b0, 2, c2);
    wait_done();
    // start while DONE is ignored
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("start_in_done", {63'd0, m_done}, 64'd1);
    check("start_in_done_rdy", {63'd0, m_rdy}, 64'd0);
    tick();

    // 2: saturation
    soft_reset();
    start_layer(0, 4);
    send_pair(32'h7FFF_FFFF, 32'h007F_FF80, 1'b0, 2, c1);
    send_pair(32'h007F_FF7F, 32'h8000_0000, 1'b0, 2, c2);
    wait_done();

    // 3: acc_valid held high across three pairs, N_OUT=6
    soft_reset();
    start_layer(1, 6);
    send_pair(32'h0000_0100, 32'h0000_0200, 1'b1, 2, c1);
    send_pair(32'h0000_0A80, 32'h0000_0000, 1'b1, 2, c2);
    send_pair(32'h0012_3456, 32'hFFFF_FFFF, 1'b1, 2, c3);
    acc_valid = 1'b0;
    check("pair_spacing_1", 64'(c2 - c1), 64'd3);
    check("pair_spacing_2", 64'(c3 - c2), 64'd3);
    wait_done();

    // 4: odd layer size, N_OUT=3
    soft_reset();
    start_layer(2, 3);
    send_pair(32'h0000_0400, 32'h0000_0500, 1'b0, 2, c1);
    send_pair(32'h0000_0600, 32'h0000_0700, 1'b0, 2, c2);
    wait_done();

    // 5a: soft reset during WR0 aborts lane 1
    soft_reset();
    start_layer(0, 4);
    send_pair(32'h0000_0500, 32'h0000_0600, 1'b0, 1, c1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_we", {63'd0, m_we}, 64'd0);
      check("abort_ready", {63'd0, m_rdy}, 64'd0);
      check("abort_done", {63'd0, m_done}, 64'd0);
    end
    tick();
    start_layer(0, 4);
    send_pair(32'h0000_0900, 32'h0000_0A00, 1'b0, 2, c1);
    send_pair(32'h0000_0B00, 32'h0000_0C00, 1'b0, 2, c2);
    wait_done();

    // 5b: asynchronous reset mid-cycle clears outputs immediately
    soft_reset();
    start_layer(0, 4);
    send_pair(32'h0000_0700, 32'h0000_0800, 1'b0, 0, c1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_we", {63'd0, we4}, 64'd0);
    check("arst_addr", {48'd0, addr4}, 64'd0);
    check("arst_wdata", {48'd0, wd4}, 64'd0);
    check("arst_ready", {63'd0, rdy4}, 64'd0);
    check("arst_done", {63'd0, done4}, 64'd0);
    tick();
    rst = 1'b1;
    start_layer(0, 4);
    send_pair(32'h0000_0D00, 32'h0000_0E00, 1'b0, 2, c1);
    send_pair(32'h0000_0F00, 32'h0000_1000, 1'b0, 2, c2);
    wait_done();

    // 6: start and reset together in IDLE
    soft_reset();
    reset = 1'b1;
    start4 = 1'b1;
    tick();
    reset = 1'b0;
    start4 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("start_reset_ready", {63'd0, m_rdy}, 64'd0);
      check("start_reset_we", {63'd0, m_we}, 64'd0);
    end

    check("sb_final", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_wb.md
Name: relu_wb

Overview:
- Writeback stage directly downstream of the two-lane MAC datapath sequenced by sm_relu.
- Accepts each pair of finished accumulator results (lane 0, lane 1) and applies ReLU.
- Rescales fixed-point by rounding right shift and saturates to the activation width.
- Serializes the pair into one activation-memory write per cycle at sequential addresses, then flags done after N_OUT neurons.

Parameters:
- ACC_WIDTH, 32, signed accumulator width per lane.
- DATA_WIDTH, 16, signed activation word width written to memory.
- FRAC_SHIFT, 8, right-shift applied to the accumulator (≥1).
- ADDR_WIDTH, 16, memory address width.
- ADDR_BASE_O, 16'h0000, first output address.
- N_OUT, 32, neurons in the layer (≥1; odd allowed).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a layer when in IDLE.
- reset  in  1  synchronous soft clear back to IDLE.
- acc_valid  in  1  acc0/acc1 hold a finished pair.
- acc0  in  ACC_WIDTH  lane-0 accumulator, signed.
- acc1  in  ACC_WIDTH  lane-1 accumulator, signed.
- acc_ready  out  1  block can capture a pair this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- done  out  1  layer complete; held until reset.

Behaviour:
- Reset state (rst=0, asynchronous): state=IDLE, counter cnt=0, holding regs=0. acc_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0.
- States: IDLE, WAIT, WR0, WR1, DONE. All outputs are registered (Moore).
- IDLE:
  - start=1 → WAIT, cnt=0.
  - Any other input is ignored.
- WAIT:
  - acc_ready=1.
  - On acc_valid & acc_ready, capture f(acc0) into h0 and f(acc1) into h1 → WR0.
  - acc_valid while acc_ready=0 is ignored; the producer must hold data until accepted.
- WR0:
  - mem_we=1, mem_addr=ADDR_BASE_O+cnt, mem_wdata=h0; cnt+=1.
  - If cnt==N_OUT-1 → DONE, else → WR1.
- WR1:
  - mem_we=1, mem_addr=ADDR_BASE_O+cnt, mem_wdata=h1; cnt+=1.
  - If cnt==N_OUT-1 → DONE, else → WAIT.
- DONE:
  - done=1, mem_we=0, acc_ready=0.
  - Stays in DONE until reset.
- Latency: pair captured on edge k; lane-0 write visible cycle k+1, lane-1 write cycle k+2.
- Throughput: one pair per 3 cycles max.
- Transform f(x):
  - x<0 → 0.
  - Otherwise r = (x + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT, computed in ACC_WIDTH+1 bits so the rounding add cannot overflow.
  - If r > 2^(DATA_WIDTH-1)-1, output 2^(DATA_WIDTH-1)-1 (saturate); else output r.
- mem_addr wraps modulo 2^ADDR_WIDTH; no error flag.
- Odd N_OUT: the final pair's lane 1 is discarded; no WR1 write occurs.
- reset=1 (synchronous):
  - Any state → IDLE, cnt=0, done=0, mem_we=0 next cycle.
  - A write in progress is aborted; no further writes.
  - reset has priority over start in the same cycle.
- start outside IDLE: ignored.
- Back-to-back layers: reset then start; the second layer starts again at ADDR_BASE_O.

Test Plan:
1. Defaults, N_OUT=4. Pairs (acc0,acc1) = (0x00000300, 0xFFFFFF00), then (0x00000180, 0x000000FF). Expected writes: addr0=3, addr1=0, addr2=2 (0x180 rounds 1.5→2), addr3=1 (0xFF rounds to 1). done rises the cycle after the addr3 write.
2. Saturation: acc0=0x7FFFFFFF → wdata=0x7FFF. acc1=0x007FFF80 → (0x7FFF80+0x80)>>8 = 0x8000, saturates to 0x7FFF. acc1=0x007FFF7F → 0x7FFF exact.
3. Handshake: hold acc_valid=1 continuously across 3 pairs. acc_ready asserts only in WAIT; exactly one capture per WAIT cycle; pairs are 3 cycles apart; 6 writes go to addresses 0..5.
4. Odd N_OUT=3. Two pairs supplied → exactly 3 writes (addrs 0,1,2); the second pair's lane 1 is never written; DONE follows.
5. Reset mid-operation:
   - reset pulse in WR0 → no WR1 write, state IDLE, done=0.
   - rst=0 asserted mid-cycle → outputs go 0 immediately, without waiting for a clock edge.
   - After either, start, then a fresh layer writes from ADDR_BASE_O again.
6. start+reset in the same cycle in IDLE → remains IDLE, acc_ready stays 0.
